dma_copy_ctrl: RTL and testbench
================================

Name: dma_copy_ctrl

Overview:
- Memory-to-memory copy sequencer that drives the DMAC's read and write channels.
- Launches a read and a write request of equal size and pops words from the DMAC read FIFO.
- Pushes each popped word through one holding register into the DMAC write FIFO, keeping a running checksum.
- Reports completion once both DMAC channels signal done.
- Sits directly between the host-facing control registers and the DMAC.

Parameters:
- DATA_WIDTH, 32, word width of the read/write FIFO data.
- ADDR_WIDTH, 32, byte address width of source and destination.
- SIZE_WIDTH, 16, width of the transfer length in words.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- go  in  1  start pulse; sampled only in IDLE.
- src_addr  in  ADDR_WIDTH  source address.
- dst_addr  in  ADDR_WIDTH  destination address.
- size  in  SIZE_WIDTH  transfer length in words.
- busy  out  1  high from go accept until done.
- done  out  1  one-cycle completion pulse.
- word_count  out  SIZE_WIDTH  words written so far.
- checksum  out  DATA_WIDTH  sum of written words, mod 2^DATA_WIDTH.
- dma_rd_go  out  1  read request pulse.
- dma_rd_size  out  SIZE_WIDTH  latched size.
- dma_rd_addr  out  ADDR_WIDTH  latched src_addr.
- dma_rd_data  in  DATA_WIDTH  read FIFO head; first-word-fall-through, valid when !dma_empty.
- dma_empty  in  1  read FIFO empty.
- dma_rd_en  out  1  pop read FIFO.
- dma_rd_done  in  1  read channel finished (pulse).
- dma_wr_go  out  1  write request pulse.
- dma_wr_size  out  SIZE_WIDTH  latched size.
- dma_wr_addr  out  ADDR_WIDTH  latched dst_addr.
- dma_wr_data  out  DATA_WIDTH  word to push.
- dma_full  in  1  write FIFO full.
- dma_wr_en  out  1  push write FIFO.
- dma_wr_done  in  1  write channel finished (pulse).

Behaviour:
- Reset: every output 0; state IDLE; holding register invalid; sticky done flags cleared. Reset mid-transfer aborts immediately, with no cleanup handshake.
- States: IDLE, START, XFER, WAIT_DONE, DONE.
- IDLE:
  - go=1 latches src, dst and size; clears word_count, checksum and the sticky done flags; sets busy.
  - Next state is START, or DONE if size==0.
  - go while busy is ignored.
- START (one cycle): dma_rd_go=1 and dma_wr_go=1 together, for exactly one cycle; then XFER.
- XFER:
  - Track rd_cnt = words popped so far.
  - dma_rd_en = !dma_empty && rd_cnt<size && (!hold_valid || dma_wr_en).
  - dma_wr_en = hold_valid && !dma_full; dma_wr_data = hold_data.
  - On pop: hold_data <= dma_rd_data, hold_valid <= 1. A pop and a push in the same cycle keep hold_valid high.
  - On push: word_count += 1; checksum += hold_data (width-truncated wrap).
  - dma_rd_en is never asserted while dma_empty=1; dma_wr_en is never asserted while dma_full=1.
  - Sustained throughput: 1 word/cycle when not empty and not full.
  - When word_count reaches size, go to WAIT_DONE.
- Sticky flags: dma_rd_done and dma_wr_done are captured in sticky flags in any state after START. They may arrive in either order, in the same cycle, or before XFER ends.
- WAIT_DONE: once both sticky flags are set, go to DONE.
- DONE (one cycle): done=1, busy=0; then IDLE. word_count and checksum hold until the next accepted go.
- size==0: no rd_go/wr_go is issued; done pulses in the cycle after go; busy is high for that one cycle only.
- Latency: go at edge N → dma_rd_go/dma_wr_go high in cycle N+1 → first possible dma_rd_en in cycle N+2 → first dma_wr_en in cycle N+3.
- Minimum busy time: size + 3 cycles plus the done-wait, assuming no stalls.
- Spurious dma_rd_en or dma_wr_en outside XFER is forbidden.

Decomposition:
- Package dma_copy_pkg holds:
  - the state enum;
  - default width localparams;
  - a DMAC request struct {addr, size}.
- One natural sub-module, dma_copy_hold: a 1-entry holding register with valid/ready semantics.
  - Inputs: push, pop.
  - Outputs: hold_valid, hold_data.
- The FSM, counters and checksum stay in the top module.

Test Plan:
- Basic copy: size=4, src=0x100, dst=0x200, FIFO supplies 1,2,3,4 with no stalls → one-cycle rd_go/wr_go carrying those addresses; four consecutive wr_en with data 1,2,3,4; checksum=10; word_count=4; done 1 cycle after both channel dones.
- Backpressure: dma_full held high for 5 cycles mid-transfer of size=8 → no wr_en and no rd_en beyond a single held word; data order preserved; checksum correct.
- Empty bubbles: dma_empty toggling every other cycle, size=6 → rd_en never coincides with empty; all 6 words written in order.
- Size zero and busy protection: go with size=0 → done the next cycle, no rd_go/wr_go. A second go during an active size=3 copy → ignored, addresses unchanged.
- Done ordering: wr_done arrives 3 cycles before rd_done, then a separate run with both in the same cycle → done exactly once, after the later of the two.
- Reset mid-op: rst_n low during XFER of size=16 → all outputs 0 asynchronously. After release, a fresh go with size=2 completes normally with checksum equal to the sum of the new data only.

Source files
------------

// File: rtl/dma_copy_pkg.sv
// Shared definitions for the memory-to-memory copy sequencer:
// FSM state codes, default widths and the DMAC request record.
package dma_copy_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int ADDR_WIDTH_DEF = 32;
  localparam int SIZE_WIDTH_DEF = 16;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_START     = 3'd1;
  localparam state_t ST_XFER      = 3'd2;
  localparam state_t ST_WAIT_DONE = 3'd3;
  localparam state_t ST_DONE      = 3'd4;

  typedef struct packed {
    logic [ADDR_WIDTH_DEF-1:0] addr;
    logic [SIZE_WIDTH_DEF-1:0] size;
  } dma_req_t;

endpackage

// File: rtl/dma_copy_hold.sv
// One-entry holding register between the DMAC read FIFO head and the write FIFO.
module dma_copy_hold
  import dma_copy_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  hold_valid,
  output logic [DATA_WIDTH-1:0] hold_data
);

  // A push in the same cycle as a pop refills the entry, so valid stays high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_valid <= 1'b0;
      hold_data  <= '0;
    end else if (push) begin
      hold_valid <= 1'b1;
      hold_data  <= din;
    end else if (pop) begin
      hold_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/dma_copy_ctrl.sv
// Copy sequencer: launches equal-size DMAC read/write requests, streams words
// from the read FIFO to the write FIFO through one holding register, and sums them.
module dma_copy_ctrl
  import dma_copy_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int SIZE_WIDTH = SIZE_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  go,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [SIZE_WIDTH-1:0] size,
  output logic                  busy,
  output logic                  done,
  output logic [SIZE_WIDTH-1:0] word_count,
  output logic [DATA_WIDTH-1:0] checksum,
  output logic                  dma_rd_go,
  output logic [SIZE_WIDTH-1:0] dma_rd_size,
  output logic [ADDR_WIDTH-1:0] dma_rd_addr,
  input  logic [DATA_WIDTH-1:0] dma_rd_data,
  input  logic                  dma_empty,
  output logic                  dma_rd_en,
  input  logic                  dma_rd_done,
  output logic                  dma_wr_go,
  output logic [SIZE_WIDTH-1:0] dma_wr_size,
  output logic [ADDR_WIDTH-1:0] dma_wr_addr,
  output logic [DATA_WIDTH-1:0] dma_wr_data,
  input  logic                  dma_full,
  output logic                  dma_wr_en,
  input  logic                  dma_wr_done
);

  state_t                state;
  logic [SIZE_WIDTH-1:0] size_q;
  logic [SIZE_WIDTH-1:0] rd_cnt;
  logic                  rd_done_s;
  logic                  wr_done_s;
  logic                  busy_q;
  logic                  hold_valid;
  logic [DATA_WIDTH-1:0] hold_data;
  logic                  in_xfer;
  logic                  capture;
  logic                  both_done;

  assign in_xfer   = (state == ST_XFER);
  assign capture   = (state == ST_START) || (state == ST_XFER) || (state == ST_WAIT_DONE);
  assign both_done = (rd_done_s || dma_rd_done) && (wr_done_s || dma_wr_done);

  assign dma_wr_en   = in_xfer && hold_valid && !dma_full;
  assign dma_rd_en   = in_xfer && !dma_empty && (rd_cnt < size_q) && (!hold_valid || dma_wr_en);
  assign dma_wr_data = hold_data;
  assign dma_rd_go   = (state == ST_START);
  assign dma_wr_go   = (state == ST_START);
  assign dma_rd_size = size_q;
  assign dma_wr_size = size_q;
  assign done        = (state == ST_DONE);
  assign busy        = busy_q;

  dma_copy_hold #(.DATA_WIDTH(DATA_WIDTH)) u_hold (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (dma_rd_en),
    .pop        (dma_wr_en),
    .din        (dma_rd_data),
    .hold_valid (hold_valid),
    .hold_data  (hold_data)
  );

  // busy rises on go accept; a zero-length copy keeps it for the DONE cycle only,
  // a normal copy drops it on the edge that enters DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      size_q      <= '0;
      rd_cnt      <= '0;
      word_count  <= '0;
      checksum    <= '0;
      rd_done_s   <= 1'b0;
      wr_done_s   <= 1'b0;
      busy_q      <= 1'b0;
      dma_rd_addr <= '0;
      dma_wr_addr <= '0;
    end else begin
      if (dma_rd_en) rd_cnt <= rd_cnt + SIZE_WIDTH'(1);
      if (dma_wr_en) begin
        word_count <= word_count + SIZE_WIDTH'(1);
        checksum   <= checksum + hold_data;
      end
      if (capture) begin
        if (dma_rd_done) rd_done_s <= 1'b1;
        if (dma_wr_done) wr_done_s <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (go) begin
            dma_rd_addr <= src_addr;
            dma_wr_addr <= dst_addr;
            size_q      <= size;
            rd_cnt      <= '0;
            word_count  <= '0;
            checksum    <= '0;
            rd_done_s   <= 1'b0;
            wr_done_s   <= 1'b0;
            busy_q      <= 1'b1;
            state       <= (size == '0) ? ST_DONE : ST_START;
          end
        end
        ST_START: state <= ST_XFER;
        ST_XFER: begin
          if (dma_wr_en && ((word_count + SIZE_WIDTH'(1)) == size_q)) state <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          if (both_done) begin
            state  <= ST_DONE;
            busy_q <= 1'b0;
          end
        end
        ST_DONE: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_copy_ctrl.sv
// Scoreboard bench for dma_copy_ctrl with a behavioural DMAC FIFO model.
module tb_dma_copy_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        go = 1'b0;
  logic [31:0] src_addr = '0;
  logic [31:0] dst_addr = '0;
  logic [15:0] size = '0;
  logic        busy;
  logic        done;
  logic [15:0] word_count;
  logic [31:0] checksum;
  logic        dma_rd_go;
  logic [15:0] dma_rd_size;
  logic [31:0] dma_rd_addr;
  logic [31:0] dma_rd_data = '0;
  logic        dma_empty = 1'b1;
  logic        dma_rd_en;
  logic        dma_rd_done = 1'b0;
  logic        dma_wr_go;
  logic [15:0] dma_wr_size;
  logic [31:0] dma_wr_addr;
  logic [31:0] dma_wr_data;
  logic        dma_full = 1'b0;
  logic        dma_wr_en;
  logic        dma_wr_done = 1'b0;

  dma_copy_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .go          (go),
    .src_addr    (src_addr),
    .dst_addr    (dst_addr),
    .size        (size),
    .busy        (busy),
    .done        (done),
    .word_count  (word_count),
    .checksum    (checksum),
    .dma_rd_go   (dma_rd_go),
    .dma_rd_size (dma_rd_size),
    .dma_rd_addr (dma_rd_addr),
    .dma_rd_data (dma_rd_data),
    .dma_empty   (dma_empty),
    .dma_rd_en   (dma_rd_en),
    .dma_rd_done (dma_rd_done),
    .dma_wr_go   (dma_wr_go),
    .dma_wr_size (dma_wr_size),
    .dma_wr_addr (dma_wr_addr),
    .dma_wr_data (dma_wr_data),
    .dma_full    (dma_full),
    .dma_wr_en   (dma_wr_en),
    .dma_wr_done (dma_wr_done)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          go_cyc = 0;
  int          first_rd = -1;
  int          first_wr = -1;
  int          last_wr = -1;
  int          wr_cnt = 0;
  int          rdgo_cnt = 0;
  int          done_cnt = 0;
  int          rd_in_full = 0;
  logic        pop_pend = 1'b0;
  logic        bubble = 1'b0;
  logic [31:0] rdq[$];
  logic [31:0] expq[$];
  logic [31:0] exp_sum = '0;
  logic [31:0] e;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Mid-cycle observation of the handshakes that take effect at the next edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (dma_rd_en) begin
        chk("rd_en_while_empty", dma_empty, 0);
        pop_pend = 1'b1;
        if (first_rd < 0) first_rd = cyc;
        if (dma_full) rd_in_full++;
      end
      if (dma_wr_en) begin
        chk("wr_en_while_full", dma_full, 0);
        if (expq.size() == 0) chk("wr_unexpected", 1, 0);
        else begin
          e = expq.pop_front();
          chk("wr_data", dma_wr_data, e);
        end
        wr_cnt++;
        if (first_wr < 0) first_wr = cyc;
        last_wr = cyc;
      end
      if (dma_rd_go) rdgo_cnt++;
      if (done) done_cnt++;
    end
  end

  // First-word-fall-through read FIFO model.
  always @(posedge clk) begin
    cyc++;
    #1;
    if (pop_pend) begin
      if (rdq.size() != 0) rdq.delete(0);
      pop_pend = 1'b0;
    end
    dma_empty   = (rdq.size() == 0) || (bubble && cyc[0]);
    dma_rd_data = (rdq.size() != 0) ? rdq[0] : 32'h0;
  end

  task automatic load(input int n, input logic [31:0] base, input logic [31:0] step);
    logic [31:0] w;
    exp_sum = '0;
    for (int i = 0; i < n; i++) begin
      w = base + step * i;
      rdq.push_back(w);
      expq.push_back(w);
      exp_sum = exp_sum + w;
    end
  endtask

  task automatic start(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n);
    wr_cnt = 0;
    first_rd = -1;
    first_wr = -1;
    last_wr = -1;
    go = 1'b1;
    src_addr = s;
    dst_addr = d;
    size = n;
    tick();
    go = 1'b0;
    go_cyc = cyc;
  endtask

  task automatic check_launch(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n);
    chk("rd_go", dma_rd_go, 1);
    chk("wr_go", dma_wr_go, 1);
    chk("rd_addr", dma_rd_addr, s);
    chk("wr_addr", dma_wr_addr, d);
    chk("rd_size", dma_rd_size, n);
    chk("wr_size", dma_wr_size, n);
    chk("busy_start", busy, 1);
    tick();
    chk("rd_go_one_cycle", dma_rd_go, 0);
    chk("wr_go_one_cycle", dma_wr_go, 0);
  endtask

  task automatic wait_words(input int n);
    int t;
    t = 0;
    while (wr_cnt < n && t < 300) begin
      tick();
      t++;
    end
    chk("words_written", wr_cnt, n);
  endtask

  // gap = cycles from wr_done to rd_done; 0 means both in the same cycle.
  task automatic finish_dones(input int gap, input int n);
    int d0;
    d0 = done_cnt;
    chk("wait_busy", busy, 1);
    chk("wait_no_done", done, 0);
    if (gap == 0) begin
      dma_rd_done = 1'b1;
      dma_wr_done = 1'b1;
      tick();
      dma_rd_done = 1'b0;
      dma_wr_done = 1'b0;
    end else begin
      dma_wr_done = 1'b1;
      tick();
      dma_wr_done = 1'b0;
      for (int i = 0; i < gap - 1; i++) begin
        chk("early_done", done, 0);
        tick();
      end
      dma_rd_done = 1'b1;
      tick();
      dma_rd_done = 1'b0;
    end
    chk("done_pulse", done, 1);
    chk("busy_at_done", busy, 0);
    chk("word_count", word_count, n);
    chk("checksum", checksum, exp_sum);
    tick();
    chk("done_once", done, 0);
    chk("busy_after", busy, 0);
    chk("done_count", done_cnt - d0, 1);
    chk("word_count_hold", word_count, n);
    chk("checksum_hold", checksum, exp_sum);
  endtask

  initial begin
    int w0;
    int r0;
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_en", dma_rd_en, 0);
    chk("rst_wr_en", dma_wr_en, 0);
    chk("rst_rd_go", dma_rd_go, 0);
    chk("rst_word_count", word_count, 0);
    chk("rst_checksum", checksum, 0);
    rst_n = 1'b1;
    tick();

    // Basic copy
    load(4, 32'd1, 32'd1);
    tick();
    start(32'h100, 32'h200, 16'd4);
    check_launch(32'h100, 32'h200, 16'd4);
    wait_words(4);
    chk("first_rd_latency", first_rd - go_cyc, 1);
    chk("first_wr_latency", first_wr - go_cyc, 2);
    chk("wr_back_to_back", last_wr - first_wr, 3);
    finish_dones(0, 4);

    // Backpressure with a wrapping checksum
    load(8, 32'hF000_0000, 32'h1000_0001);
    tick();
    start(32'h1000, 32'h2000, 16'd8);
    check_launch(32'h1000, 32'h2000, 16'd8);
    tick();
    tick();
    dma_full = 1'b1;
    rd_in_full = 0;
    w0 = wr_cnt;
    repeat (5) tick();
    dma_full = 1'b0;
    chk("no_wr_while_full", wr_cnt - w0, 0);
    chk("rd_bounded_while_full", (rd_in_full <= 1), 1);
    wait_words(8);
    finish_dones(3, 8);

    // Empty bubbles
    bubble = 1'b1;
    load(6, 32'hA5A5_0000, 32'h0000_0101);
    tick();
    start(32'h40, 32'h80, 16'd6);
    check_launch(32'h40, 32'h80, 16'd6);
    wait_words(6);
    bubble = 1'b0;
    finish_dones(0, 6);

    // Size zero
    r0 = rdgo_cnt;
    exp_sum = '0;
    start(32'h10, 32'h20, 16'd0);
    chk("sz0_busy", busy, 1);
    chk("sz0_done", done, 1);
    chk("sz0_rd_go", dma_rd_go, 0);
    chk("sz0_word_count", word_count, 0);
    chk("sz0_checksum", checksum, 0);
    tick();
    chk("sz0_done_end", done, 0);
    chk("sz0_busy_end", busy, 0);
    chk("sz0_no_go", rdgo_cnt - r0, 0);

    // go while busy is ignored
    load(3, 32'd7, 32'd1);
    tick();
    start(32'h300, 32'h400, 16'd3);
    check_launch(32'h300, 32'h400, 16'd3);
    go = 1'b1;
    src_addr = 32'hDEAD;
    dst_addr = 32'hBEEF;
    size = 16'd9;
    tick();
    go = 1'b0;
    chk("busy_go_rd_addr", dma_rd_addr, 32'h300);
    chk("busy_go_wr_addr", dma_wr_addr, 32'h400);
    chk("busy_go_size", dma_rd_size, 3);
    wait_words(3);
    finish_dones(0, 3);

    // Reset mid-transfer
    load(16, 32'h1234_0000, 32'd3);
    tick();
    start(32'h700, 32'h800, 16'd16);
    check_launch(32'h700, 32'h800, 16'd16);
    repeat (4) tick();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_rd_en", dma_rd_en, 0);
    chk("arst_wr_en", dma_wr_en, 0);
    chk("arst_word_count", word_count, 0);
    chk("arst_checksum", checksum, 0);
    chk("arst_rd_addr", dma_rd_addr, 0);
    chk("arst_wr_data", dma_wr_data, 0);
    chk("arst_rd_size", dma_rd_size, 0);
    rdq.delete();
    expq.delete();
    pop_pend = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    load(2, 32'h55, 32'h55);
    tick();
    start(32'h500, 32'h600, 16'd2);
    check_launch(32'h500, 32'h600, 16'd2);
    wait_words(2);
    finish_dones(3, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
